// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter
// Purpose  : Two-requester arbiter/sequencer in front of a shared combinational
//            ALU. Serves one request at a time (IDLE -> EXEC -> DONE), latches
//            the winner's opcode/operands onto the ALU, registers the result
//            and returns it with a one-hot, one-cycle done pulse.
// Options  : ALU_ARB_ROUND_ROBIN_EN defined   -> round-robin tie-break
//            ALU_ARB_ROUND_ROBIN_EN undefined -> fixed priority, client 0 wins
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int N_PARAMETER = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [1:0]             opcode0,
  input  logic [1:0]             opcode1,
  input  logic [N_PARAMETER-1:0] A0,
  input  logic [N_PARAMETER-1:0] B0,
  input  logic [N_PARAMETER-1:0] A1,
  input  logic [N_PARAMETER-1:0] B1,
  output logic [1:0]             alu_opcode,
  output logic [N_PARAMETER-1:0] alu_A,
  output logic [N_PARAMETER-1:0] alu_B,
  input  logic [N_PARAMETER-1:0] alu_result,
  output logic [N_PARAMETER-1:0] result,
  output logic [1:0]             done,
  output logic                   gnt,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   winner;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Client served most recently; reset to 1 so client 0 wins the first tie.
  logic   last;

  // Round-robin pick: a lone requester wins, a tie goes to the client not served last.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b10)
      winner = 1'b1;
    else if (req == 2'b11)
      winner = ~last;
  end
`else
  // Fixed-priority pick: client 0 whenever it requests, otherwise client 1.
  always_comb begin
    winner = ~req[0];
  end
`endif

  // Transaction sequencer: grant and latch in IDLE, capture in EXEC, retire in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      result     <= '0;
      done       <= 2'b00;
      gnt        <= 1'b0;
      busy       <= 1'b0;
      alu_opcode <= 2'b00;
      alu_A      <= '0;
      alu_B      <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last       <= 1'b1;
`endif
    end else begin
      done <= 2'b00;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            gnt        <= winner;
            alu_opcode <= winner ? opcode1 : opcode0;
            alu_A      <= winner ? A1 : A0;
            alu_B      <= winner ? B1 : B0;
            busy       <= 1'b1;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          // done is registered here so the pulse is visible during DONE.
          result <= alu_result;
          done   <= gnt ? 2'b10 : 2'b01;
          state  <= S_DONE;
        end
        S_DONE: begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last  <= gnt;
`endif
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter with N_PARAMETER = 4.
//            Expected tie-break order follows ALU_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] opcode0;
  logic [1:0] opcode1;
  logic [3:0] A0;
  logic [3:0] B0;
  logic [3:0] A1;
  logic [3:0] B1;
  logic [1:0] alu_opcode;
  logic [3:0] alu_A;
  logic [3:0] alu_B;
  logic [3:0] alu_result;
  logic [3:0] result;
  logic [1:0] done;
  logic       gnt;
  logic       busy;

  int tests;
  int fails;

  alu_arbiter #(.N_PARAMETER(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .opcode0    (opcode0),
    .opcode1    (opcode1),
    .A0         (A0),
    .B0         (B0),
    .A1         (A1),
    .B1         (B1),
    .alu_opcode (alu_opcode),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_result (alu_result),
    .result     (result),
    .done       (done),
    .gnt        (gnt),
    .busy       (busy)
  );

  // Shared combinational ALU the arbiter fronts.
  always_comb begin
    case (alu_opcode)
      2'd0:    alu_result = alu_A + alu_B;
      2'd1:    alu_result = alu_A | alu_B;
      2'd2:    alu_result = alu_A - alu_B;
      default: alu_result = alu_A ^ alu_B;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"},   {30'd0, done},       32'd0);
    chk({tag, "_result"}, {28'd0, result},     32'd0);
    chk({tag, "_gnt"},    {31'd0, gnt},        32'd0);
    chk({tag, "_busy"},   {31'd0, busy},       32'd0);
    chk({tag, "_aluop"},  {30'd0, alu_opcode}, 32'd0);
    chk({tag, "_aluA"},   {28'd0, alu_A},      32'd0);
    chk({tag, "_aluB"},   {28'd0, alu_B},      32'd0);
  endtask

  // Waits (bounded) on negedges for the next done pulse, then checks it.
  task automatic wait_done(input string tag, input logic [1:0] exp_done,
                           input logic [3:0] exp_res, input logic exp_gnt,
                           input int exp_lat);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (done == 2'b00 && cnt < 8);
    chk({tag, "_lat"},    cnt,                 exp_lat);
    chk({tag, "_done"},   {30'd0, done},       {30'd0, exp_done});
    chk({tag, "_result"}, {28'd0, result},     {28'd0, exp_res});
    chk({tag, "_gnt"},    {31'd0, gnt},        {31'd0, exp_gnt});
    chk({tag, "_busy"},   {31'd0, busy},       32'd1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    req     = 2'b00;
    opcode0 = 2'd0; A0 = 4'h0; B0 = 4'h0;
    opcode1 = 2'd0; A1 = 4'h0; B1 = 4'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_init");
    rst = 1'b0;

    // Client 0 alone: 9 + 8 wraps to 1
    @(negedge clk);
    opcode0 = 2'd0; A0 = 4'h9; B0 = 4'h8;
    req = 2'b01;
    @(negedge clk);
    chk("c0_exec_busy", {31'd0, busy},       32'd1);
    chk("c0_exec_op",   {30'd0, alu_opcode}, 32'd0);
    chk("c0_exec_A",    {28'd0, alu_A},      32'h9);
    chk("c0_exec_B",    {28'd0, alu_B},      32'h8);
    chk("c0_exec_done", {30'd0, done},       32'd0);
    wait_done("c0_add", 2'b01, 4'h1, 1'b0, 1);
    req = 2'b00;
    @(negedge clk);
    chk("c0_idle_done", {30'd0, done},  32'd0);
    chk("c0_idle_busy", {31'd0, busy},  32'd0);
    chk("c0_hold_A",    {28'd0, alu_A}, 32'h9);

    // Client 1 alone: 5 | A = F, then re-request 3 - 5 = E
    opcode1 = 2'd1; A1 = 4'h5; B1 = 4'hA;
    req = 2'b10;
    wait_done("c1_or", 2'b10, 4'hF, 1'b1, 2);
    opcode1 = 2'd2; A1 = 4'h3; B1 = 4'h5;
    wait_done("c1_sub", 2'b10, 4'hE, 1'b1, 3);
    req = 2'b00;
    @(negedge clk);

    // Tie: client 0 C ^ A = 6, client 1 3 - 5 = E, both keep requesting
    opcode0 = 2'd3; A0 = 4'hC; B0 = 4'hA;
    opcode1 = 2'd2; A1 = 4'h3; B1 = 4'h5;
    req = 2'b11;
    wait_done("tie1", 2'b01, 4'h6, 1'b0, 2);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    wait_done("tie2", 2'b10, 4'hE, 1'b1, 3);
    wait_done("tie3", 2'b01, 4'h6, 1'b0, 3);
    wait_done("tie4", 2'b10, 4'hE, 1'b1, 3);
    req = 2'b00;
`else
    wait_done("tie2", 2'b01, 4'h6, 1'b0, 3);
    wait_done("tie3", 2'b01, 4'h6, 1'b0, 3);
    wait_done("tie4", 2'b01, 4'h6, 1'b0, 3);
    req = 2'b10;
    wait_done("starve_end", 2'b10, 4'hE, 1'b1, 3);
    req = 2'b00;
`endif
    @(negedge clk);

    // Reset during EXEC aborts the transaction; held req is served afresh
    opcode0 = 2'd0; A0 = 4'h9; B0 = 4'h8;
    req = 2'b01;
    @(negedge clk);
    chk("abort_in_exec", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    chk("abort_no_done", {30'd0, done}, 32'd0);
    rst = 1'b0;
    wait_done("after_rst", 2'b01, 4'h1, 1'b0, 2);
    req = 2'b00;
    @(negedge clk);

    // Client 1 arrives during client 0 EXEC; served right after, 3 cycles later
    opcode0 = 2'd1; A0 = 4'h5; B0 = 4'hA;
    opcode1 = 2'd2; A1 = 4'h3; B1 = 4'h5;
    req = 2'b01;
    @(negedge clk);
    req = 2'b11;
    wait_done("late_c0", 2'b01, 4'hF, 1'b0, 1);
    req = 2'b10;
    wait_done("late_c1", 2'b10, 4'hE, 1'b1, 3);
    req = 2'b00;
    @(negedge clk);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared combinational `ALU` (opcodes add/or/sub/xor, `N_PARAMETER`-bit operands). It sits between two client blocks and one `ALU` instance. It accepts one request at a time, drives latched operands and opcode into the ALU, and registers the result. It returns the result to the winning requester with a one-cycle done pulse.

## Interface
Parameters:
- `N_PARAMETER`, default 4: operand and result width, matching the `ALU` parameter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 2: `req[i]` is the request from client i.
- `opcode0`, `opcode1`, input, 2 each: per-client opcode. 0 = A+B, 1 = A|B, 2 = A-B, 3 = A^B.
- `A0`, `B0`, `A1`, `B1`, input, N each: per-client operands.
- `alu_opcode`, output, 2: opcode driven to the ALU.
- `alu_A`, `alu_B`, output, N each: operands driven to the ALU.
- `alu_result`, input, N: ALU result.
- `result`, output, N: registered result, valid while `done` is nonzero.
- `done`, output, 2: one-hot pulse; `done[i]` means client i's request is retired.
- `gnt`, output, 1: index of the client currently being served.
- `busy`, output, 1: high in EXEC and DONE.

## Operation
- FSM with three states: IDLE, EXEC, DONE.
- IDLE:
  - If any `req` bit is high, pick a winner (see Configuration).
  - Latch the winner's opcode, A and B into internal registers.
  - Set `gnt` to the winner and go to EXEC.
  - If no `req` bit is high, stay in IDLE.
- EXEC: `alu_*` outputs carry the latched values. Capture `alu_result` into `result` and go to DONE.
- DONE: assert `done[gnt]` for exactly this cycle, update the last-served pointer to `gnt`, and go to IDLE.
- `alu_*` outputs hold the latched registers in every state. They change only on a grant.
- Request handshake:
  - A client holds `req[i]` and its operands stable from assertion until it samples `done[i]`.
  - The `done` pulse retires the request.
  - Any `req[i]` sampled high in a later IDLE cycle is a new request. The client either presents new operands in the cycle after `done[i]` or drops `req[i]`.
- Requests that arrive while `busy` is high wait. Nothing is queued beyond the live `req` level.
- Arithmetic is the ALU's, modulo 2^N:
  - Add and sub wrap with no carry or borrow output.
  - Sub is two's complement.
- Requests are never dropped or reordered. Each transaction produces exactly one `done` pulse.

## Timing
- Reset values: state IDLE; `result`, `done`, `gnt`, `busy`, `alu_opcode`, `alu_A`, `alu_B` all 0; last-served pointer = 1, so client 0 wins the first tie.
- Latency: `req` sampled high in IDLE at cycle 0 → EXEC in cycle 1 → `done` and `result` valid in cycle 2.
- Throughput: one transaction per 3 cycles. The next grant can happen in the cycle after DONE.
- Simultaneous requests: both bits high in the same IDLE cycle resolve in that cycle. Exactly one client is granted.
- Reset mid-transaction (EXEC or DONE): the transaction is aborted immediately, no `done` pulse is issued, and every output goes to its reset value. A client still holding `req` after reset release is served as a new request.
- `busy` is 0 in IDLE and 1 in EXEC and DONE.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - On a tie, grant the client that is not the last-served pointer.
  - A single requester is always granted.
- `ALU_ARB_ROUND_ROBIN_EN` undefined: fixed priority. Client 0 always wins a tie, and the last-served pointer is unused.
- All timing is identical in both builds.

## Test plan
All scenarios use `N_PARAMETER` = 4.
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately, `busy` = 0.
- Client 0 only, opcode 0, A=9, B=8 → `done` = 01 two cycles after request, `result` = 0001 (wrap), `gnt` = 0.
- Client 1 only, opcode 1, A=5, B=A → `done` = 10, `result` = 1111. Then opcode 2, A=3, B=5 → `result` = 1110.
- Both clients request in the same cycle (client 0 opcode 3, A=C, B=A; client 1 opcode 2, A=3, B=5), both re-requesting immediately after each `done`:
  - With the macro: grant order 0, 1, 0, 1; results 0110, 1110 alternating.
  - Without the macro: client 0 every time, client 1 starved while client 0 holds `req`.
- Assert `rst` during EXEC of a client-0 request → no `done` pulse. After release, with `req[0]` still high, a fresh transaction completes with the correct result.
- Client 1 requests while client 0 is in EXEC → client 1 is granted in the IDLE cycle after client 0's DONE, and its `done` pulse comes 3 cycles after client 0's.
